// File: rtl/line_matrix_ctrl.sv
// line_matrix_ctrl: shadow/active route tables for a bank of line_mux
// instances. A sweep copies the shadow table onto the shared mux programming
// bus one output per cycle and records each applied entry in the active table.
module line_matrix_ctrl #(
    parameter int unsigned NUM_INPUTS  = 10,
    parameter int unsigned NUM_OUTPUTS = 10
) (
    input  logic                                           clk,
    input  logic                                           rstn,
    input  logic                                           cfg_wr,
    input  logic [((NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1)-1:0] cfg_out,
    input  logic [$clog2(NUM_INPUTS+2)-1:0]                cfg_in,
    input  logic                                           clear,
    input  logic                                           apply,
    input  logic                                           err_clr,
    input  logic [((NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1)-1:0] rd_out,
    output logic [$clog2(NUM_INPUTS+2)-1:0]                rd_data,
    output logic [((NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1)-1:0] output_select,
    output logic [$clog2(NUM_INPUTS+2)-1:0]                input_select,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           pending,
    output logic                                           err
);

    localparam int unsigned ISW      = $clog2(NUM_INPUTS + 2);
    localparam int unsigned OSW      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int unsigned NUM_CODES = NUM_INPUTS + 2;
    localparam logic [OSW-1:0] LAST_K = OSW'(NUM_OUTPUTS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [OSW-1:0]     k_q, k_d;
    logic [ISW-1:0]     shadow_q [NUM_OUTPUTS];
    logic [ISW-1:0]     shadow_d [NUM_OUTPUTS];
    logic [ISW-1:0]     active_q [NUM_OUTPUTS];
    logic [ISW-1:0]     active_d [NUM_OUTPUTS];
    logic [OSW-1:0]     osel_d;
    logic [ISW-1:0]     isel_d;
    logic [ISW-1:0]     rd_data_d;
    logic               busy_d, done_d, pending_d, err_d;
    logic               new_err;
    logic               wr_legal;
    logic [OSW-1:0]     k_inc;

    assign wr_legal = (32'(cfg_out) < NUM_OUTPUTS) && (32'(cfg_in) < NUM_CODES);
    assign k_inc    = k_q + OSW'(1);

    // State, tables and registered outputs; reset has priority over everything
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            k_q           <= '0;
            output_select <= '0;
            input_select  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pending       <= 1'b0;
            err           <= 1'b0;
            rd_data       <= '0;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            output_select <= osel_d;
            input_select  <= isel_d;
            busy          <= busy_d;
            done          <= done_d;
            pending       <= pending_d;
            err           <= err_d;
            rd_data       <= rd_data_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    // Next-state: table updates, sweep sequencing and error detection
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        osel_d    = output_select;
        isel_d    = input_select;
        busy_d    = busy;
        done_d    = 1'b0;
        pending_d = pending;
        new_err   = 1'b0;

        case (state_q)
            IDLE: begin
                // clear beats a simultaneous write, which is dropped silently
                if (clear) begin
                    for (int i = 0; i < NUM_OUTPUTS; i++) begin
                        shadow_d[i] = '0;
                    end
                    pending_d = 1'b1;
                end else if (cfg_wr) begin
                    if (wr_legal) begin
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            if (OSW'(i) == cfg_out) begin
                                shadow_d[i] = cfg_in;
                            end
                        end
                        pending_d = 1'b1;
                    end else begin
                        new_err = 1'b1;
                    end
                end
                // entry 0 comes from the updated table so a same-cycle write is seen
                if (apply) begin
                    state_d   = SWEEP;
                    k_d       = '0;
                    osel_d    = '0;
                    isel_d    = shadow_d[0];
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            SWEEP: begin
                for (int i = 0; i < NUM_OUTPUTS; i++) begin
                    if (OSW'(i) == k_q) begin
                        active_d[i] = input_select;
                    end
                end
                if (cfg_wr || clear || apply) begin
                    new_err = 1'b1;
                end
                // bus holds its final pair after the last output is applied
                if (k_q == LAST_K) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    k_d    = k_inc;
                    osel_d = k_inc;
                    for (int i = 0; i < NUM_OUTPUTS; i++) begin
                        if (OSW'(i) == k_inc) begin
                            isel_d = shadow_q[i];
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // a new error wins over a simultaneous clear request
        if (err_clr) begin
            err_d = new_err;
        end else begin
            err_d = err | new_err;
        end
    end

    // Active-table readback; out-of-range indices read as 0
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (OSW'(i) == rd_out) begin
                rd_data_d = active_q[i];
            end
        end
    end

endmodule

// File: tb/tb_line_matrix_ctrl.sv
// Directed bench for line_matrix_ctrl with a behavioural model of the mux bank.
module tb_line_matrix_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cfg_wr;
    logic [3:0] cfg_out;
    logic [3:0] cfg_in;
    logic       clear;
    logic       apply;
    logic       err_clr;
    logic [3:0] rd_out;
    logic [3:0] rd_data;
    logic [3:0] output_select;
    logic [3:0] input_select;
    logic       busy;
    logic       done;
    logic       pending;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int dc;

    logic [9:0] input_lines = 10'b1011001110;
    logic [3:0] mux_code [10];

    line_matrix_ctrl #(.NUM_INPUTS(10), .NUM_OUTPUTS(10)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_wr        (cfg_wr),
        .cfg_out       (cfg_out),
        .cfg_in        (cfg_in),
        .clear         (clear),
        .apply         (apply),
        .err_clr       (err_clr),
        .rd_out        (rd_out),
        .rd_data       (rd_data),
        .output_select (output_select),
        .input_select  (input_select),
        .busy          (busy),
        .done          (done),
        .pending       (pending),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Mux bank model: each mux latches the bus when addressed
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 10; i++) mux_code[i] <= 4'd0;
        end else if (output_select < 4'd10) begin
            mux_code[output_select] <= input_select;
        end
    end

    always @(posedge clk) begin
        if (rstn && done) done_cnt <= done_cnt + 1;
    end

    function automatic logic mux_out(input int o);
        logic [3:0] c;
        c = mux_code[o];
        if (c == 4'd0) return 1'b0;
        if (c == 4'd1) return 1'b1;
        return input_lines[c - 4'd2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic readback(input int idx, input logic [3:0] exp, input string tag);
        rd_out = 4'(idx);
        tick();
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rstn = 1'b0; cfg_wr = 1'b0; cfg_out = '0; cfg_in = '0;
        clear = 1'b0; apply = 1'b0; err_clr = 1'b0; rd_out = '0;

        // Reset and idle
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check("rst_osel", 32'(output_select), 0);
        check("rst_isel", 32'(input_select), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_err", 32'(err), 0);
        for (int i = 0; i < 12; i++) readback(i, 4'd0, "rst_rd");

        // Full sweep of shadow[k] = k+2
        for (int k = 0; k < 10; k++) begin
            cfg_wr = 1'b1; cfg_out = 4'(k); cfg_in = 4'(k + 2);
            tick();
        end
        cfg_wr = 1'b0;
        check("wr_pending", 32'(pending), 1);
        apply = 1'b1;
        tick();
        apply = 1'b0;
        check("sw_busy0", 32'(busy), 1);
        check("sw_osel0", 32'(output_select), 0);
        check("sw_isel0", 32'(input_select), 2);
        check("sw_pending", 32'(pending), 0);
        for (int k = 1; k < 10; k++) begin
            tick();
            check("sw_osel", 32'(output_select), 32'(k));
            check("sw_isel", 32'(input_select), 32'(k + 2));
            check("sw_busy", 32'(busy), 1);
            check("sw_done_early", 32'(done), 0);
        end
        tick();
        check("sw_busy_end", 32'(busy), 0);
        check("sw_done", 32'(done), 1);
        check("sw_osel_hold", 32'(output_select), 9);
        check("sw_isel_hold", 32'(input_select), 11);
        tick();
        check("sw_done_pulse", 32'(done), 0);
        check("sw_done_cnt", 32'(done_cnt), 1);
        for (int k = 0; k < 10; k++) readback(k, 4'(k + 2), "sw_rd");
        for (int o = 0; o < 10; o++) check("sw_mux", 32'(mux_out(o)), 32'(input_lines[o]));

        // Illegal writes
        cfg_wr = 1'b1; cfg_out = 4'd0; cfg_in = 4'd12;
        tick();
        cfg_wr = 1'b0;
        check("ill_in_err", 32'(err), 1);
        check("ill_in_pending", 32'(pending), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ill_errclr", 32'(err), 0);
        cfg_wr = 1'b1; cfg_out = 4'd10; cfg_in = 4'd5;
        tick();
        cfg_wr = 1'b0;
        check("ill_out_err", 32'(err), 1);
        check("ill_out_pending", 32'(pending), 0);
        cfg_wr = 1'b1; cfg_out = 4'd10; err_clr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        check("errclr_vs_new", 32'(err), 1);
        tick();
        err_clr = 1'b0;
        check("errclr_again", 32'(err), 0);

        // Requests while busy
        dc = done_cnt;
        apply = 1'b1;
        tick();
        apply = 1'b0;
        repeat (3) tick();
        cfg_wr = 1'b1; cfg_out = 4'd8; cfg_in = 4'd0;
        tick();
        cfg_wr = 1'b0;
        check("busy_wr_err", 32'(err), 1);
        tick();
        apply = 1'b1;
        tick();
        apply = 1'b0;
        check("busy_ap_busy", 32'(busy), 1);
        repeat (4) tick();
        check("busy_done", 32'(done), 1);
        repeat (3) tick();
        check("busy_done_cnt", 32'(done_cnt), 32'(dc + 1));
        check("busy_idle", 32'(busy), 0);
        for (int k = 0; k < 10; k++) readback(k, 4'(k + 2), "busy_rd");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("busy_errclr", 32'(err), 0);

        // apply with a same-cycle write to entry 0
        cfg_wr = 1'b1; cfg_out = 4'd0; cfg_in = 4'd1; apply = 1'b1;
        tick();
        cfg_wr = 1'b0; apply = 1'b0;
        check("apwr_osel", 32'(output_select), 0);
        check("apwr_isel", 32'(input_select), 1);
        check("apwr_err", 32'(err), 0);
        repeat (10) tick();
        check("apwr_done", 32'(done), 1);
        readback(0, 4'd1, "apwr_rd0");
        readback(1, 4'd3, "apwr_rd1");

        // Reset mid-sweep
        dc = done_cnt;
        apply = 1'b1;
        tick();
        apply = 1'b0;
        tick();
        cfg_wr = 1'b1; cfg_out = 4'd3; cfg_in = 4'd3;
        tick();
        cfg_wr = 1'b0;
        check("mid_err_set", 32'(err), 1);
        repeat (2) tick();
        rstn = 1'b0;
        tick();
        check("mid_busy", 32'(busy), 0);
        check("mid_osel", 32'(output_select), 0);
        check("mid_isel", 32'(input_select), 0);
        check("mid_err", 32'(err), 0);
        check("mid_done", 32'(done), 0);
        rstn = 1'b1;
        repeat (12) tick();
        check("mid_no_done", 32'(done_cnt), 32'(dc));
        check("mid_busy_after", 32'(busy), 0);
        for (int k = 0; k < 10; k++) readback(k, 4'd0, "mid_rd");

        // clear with a same-cycle write
        cfg_wr = 1'b1; cfg_out = 4'd5; cfg_in = 4'd9;
        tick();
        clear = 1'b1; cfg_out = 4'd4; cfg_in = 4'd7;
        tick();
        clear = 1'b0; cfg_wr = 1'b0;
        check("clr_err", 32'(err), 0);
        check("clr_pending", 32'(pending), 1);
        apply = 1'b1;
        tick();
        apply = 1'b0;
        repeat (10) tick();
        check("clr_done", 32'(done), 1);
        readback(4, 4'd0, "clr_rd4");
        readback(5, 4'd0, "clr_rd5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
